// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_pkg
// Description : Shared definitions for the HI/LO multiply/divide unit:
//               operand width, iteration count, the 5-bit ALU control
//               codes, the FSM state type and small opcode-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    localparam int WIDTH      = 32;
    localparam int ITERATIONS = 32;
    localparam int COUNT_W    = 5;

    // ALU control codes (same encoding the ALU control generator emits)
    localparam logic [4:0] OPAND   = 5'd0;
    localparam logic [4:0] OPOR    = 5'd1;
    localparam logic [4:0] OPADD   = 5'd2;
    localparam logic [4:0] OPXOR   = 5'd3;
    localparam logic [4:0] OPNOR   = 5'd4;
    localparam logic [4:0] OPSUB   = 5'd6;
    localparam logic [4:0] OPSLT   = 5'd7;
    localparam logic [4:0] OPSLL   = 5'd8;
    localparam logic [4:0] OPSRL   = 5'd9;
    localparam logic [4:0] OPSRA   = 5'd10;
    localparam logic [4:0] OPSLTU  = 5'd11;
    localparam logic [4:0] OPLUI   = 5'd12;
    localparam logic [4:0] OPMULT  = 5'd16;
    localparam logic [4:0] OPMULTU = 5'd17;
    localparam logic [4:0] OPDIV   = 5'd18;
    localparam logic [4:0] OPDIVU  = 5'd19;
    localparam logic [4:0] OPMADD  = 5'd20;
    localparam logic [4:0] OPMADDU = 5'd21;
    localparam logic [4:0] OPMSUB  = 5'd22;
    localparam logic [4:0] OPMSUBU = 5'd23;
    localparam logic [4:0] OPMTHI  = 5'd24;
    localparam logic [4:0] OPMTLO  = 5'd25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } mdu_state_t;

    // Codes that need the 32-step shift engine
    function automatic logic op_is_iterative(input logic [4:0] op);
        return op inside {OPMULT, OPMULTU, OPDIV, OPDIVU,
                          OPMADD, OPMADDU, OPMSUB, OPMSUBU};
    endfunction

    function automatic logic op_is_div(input logic [4:0] op);
        return op inside {OPDIV, OPDIVU};
    endfunction

    // Signed variants work on magnitudes and fix the sign at the end
    function automatic logic op_is_signed(input logic [4:0] op);
        return op inside {OPMULT, OPDIV, OPMADD, OPMSUB};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : mdu_datapath
// Description : Iterative radix-2 engine for the multiply/divide unit.
//               Holds the 64-bit shift register, a shared 33-bit
//               adder/subtractor, operand magnitude/sign capture, the step
//               counter and the final sign correction.
// Ports       : clk, rst_n     - clock, async active-low reset
//               i_load         - capture operands and opcode class
//               i_step         - perform one radix-2 step
//               i_op           - control code (sampled with i_load)
//               i_a, i_b       - rs / rt operands (sampled with i_load)
//               o_last         - current step is the final one
//               o_result       - corrected result {HI, LO}
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_datapath
    import mult_div_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [4:0]           i_op,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_result
);

    localparam logic [COUNT_W-1:0] c_last_count = COUNT_W'(ITERATIONS - 1);

    // Multiply: acc = {partial product, remaining multiplier bits}
    // Divide  : acc = {partial remainder, dividend/quotient bits}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   operand_q, operand_d;     // multiplicand or divisor
    logic [WIDTH-1:0]   a_orig_q, a_orig_d;       // raw rs for divide-by-zero
    logic               neg_main_q, neg_main_d;   // product / quotient sign
    logic               neg_rem_q, neg_rem_d;     // remainder sign
    logic               div_zero_q, div_zero_d;
    logic               is_div_q, is_div_d;
    logic [COUNT_W-1:0] count_q, count_d;

    // Operand capture
    logic               w_signed;
    logic               w_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    assign w_signed = op_is_signed(i_op);
    assign w_div    = op_is_div(i_op);
    assign w_a_neg  = w_signed & i_a[WIDTH-1];
    assign w_b_neg  = w_signed & i_b[WIDTH-1];
    // -2^31 maps to 0x80000000, which is the correct unsigned magnitude
    assign w_a_mag  = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_b_mag  = w_b_neg ? (~i_b + 1'b1) : i_b;

    // Shared adder: add multiplicand for multiply, subtract divisor
    // (invert + carry-in) for divide. Bit 33 of the sum is the no-borrow flag.
    logic [WIDTH:0]     w_lhs;
    logic [WIDTH:0]     w_rhs;
    logic [WIDTH+1:0]   w_sum;
    logic               w_fits;
    logic [2*WIDTH-1:0] w_step_next;

    assign w_lhs  = is_div_q ? {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]}
                             : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign w_rhs  = is_div_q ? ~{1'b0, operand_q}
                             : (acc_q[0] ? {1'b0, operand_q} : '0);
    assign w_sum  = {1'b0, w_lhs} + {1'b0, w_rhs} + {{(WIDTH+1){1'b0}}, is_div_q};
    assign w_fits = w_sum[WIDTH+1];

    // Restoring division keeps the shifted remainder when the trial
    // subtraction borrows; multiplication shifts the 33-bit sum back in.
    assign w_step_next = is_div_q
        ? {(w_fits ? w_sum[WIDTH-1:0] : w_lhs[WIDTH-1:0]), acc_q[WIDTH-2:0], w_fits}
        : {w_sum[WIDTH:0], acc_q[WIDTH-1:1]};

    always_comb begin
        acc_d      = acc_q;
        operand_d  = operand_q;
        a_orig_d   = a_orig_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        is_div_d   = is_div_q;
        count_d    = count_q;
        if (i_load) begin
            acc_d      = {{WIDTH{1'b0}}, (w_div ? w_a_mag : w_b_mag)};
            operand_d  = w_div ? w_b_mag : w_a_mag;
            a_orig_d   = i_a;
            neg_main_d = w_a_neg ^ w_b_neg;
            neg_rem_d  = w_a_neg;
            div_zero_d = w_div & (i_b == '0);
            is_div_d   = w_div;
            count_d    = '0;
        end else if (i_step) begin
            acc_d   = w_step_next;
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            operand_q  <= '0;
            a_orig_q   <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            is_div_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            acc_q      <= acc_d;
            operand_q  <= operand_d;
            a_orig_q   <= a_orig_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            is_div_q   <= is_div_d;
            count_q    <= count_d;
        end
    end

    assign o_last = (count_q == c_last_count);

    // Sign correction of the finished magnitudes
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_quot = neg_main_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign w_rem  = neg_rem_q  ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                               : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        o_result = acc_q;
        if (!is_div_q) begin
            o_result = neg_main_q ? (~acc_q + 1'b1) : acc_q;
        end else if (div_zero_q) begin
            // Divide by zero bypasses sign correction entirely
            o_result = {a_orig_q, {WIDTH{1'b1}}};
        end else begin
            o_result = {w_rem, w_quot};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multi-cycle multiply/divide unit owning the HI/LO pair.
//               Runs MULT/DIV/MADD/MSUB (signed and unsigned) in 34 cycles
//               and MTHI/MTLO in a single cycle.
// Ports       : iCLK            - clock (rising edge)
//               iRST            - async active-low reset
//               iStart          - request, sampled only in IDLE
//               iControlSignal  - 5-bit ALU control code
//               iA, iB          - rs / rt operands
//               oBusy           - operation in progress (registered)
//               oDone           - one-cycle pulse after HI/LO update
//               oHI, oLO        - HI / LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [4:0]       iControlSignal,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oHI,
    output logic [WIDTH-1:0] oLO
);

    mdu_state_t        state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [4:0]        op_q, op_d;

    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic [2*WIDTH-1:0] w_result;
    logic [2*WIDTH-1:0] w_acc;

    assign w_acc = {hi_q, lo_q};

    mdu_datapath u_datapath (
        .clk      (iCLK),
        .rst_n    (iRST),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_op     (iControlSignal),
        .i_a      (iA),
        .i_b      (iB),
        .o_last   (w_last),
        .o_result (w_result)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        w_load  = 1'b0;
        w_step  = 1'b0;
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    if (op_is_iterative(iControlSignal)) begin
                        w_load  = 1'b1;
                        op_d    = iControlSignal;
                        state_d = RUN;
                    end else if (iControlSignal == OPMTHI) begin
                        hi_d   = iA;
                        done_d = 1'b1;
                    end else if (iControlSignal == OPMTLO) begin
                        lo_d   = iA;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                case (op_q)
                    OPMULT, OPMULTU, OPDIV, OPDIVU: {hi_d, lo_d} = w_result;
                    OPMADD, OPMADDU:                {hi_d, lo_d} = w_acc + w_result;
                    OPMSUB, OPMSUBU:                {hi_d, lo_d} = w_acc - w_result;
                    default: ;
                endcase
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Busy is a registered view of "not going back to IDLE"
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
        end
    end

    assign oBusy = busy_q;
    assign oDone = done_q;
    assign oHI   = hi_q;
    assign oLO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit. A cycle-level
//               behavioural model (plain 64-bit arithmetic plus a latency
//               countdown) is compared against the DUT every cycle; directed
//               literal checks pin known results and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iStart = 1'b0;
    logic [4:0]  iControlSignal = 5'd0;
    logic [31:0] iA = 32'd0;
    logic [31:0] iB = 32'd0;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oHI;
    logic [31:0] oLO;

    int checks = 0;
    int errors = 0;

    mult_div_unit dut (
        .iCLK           (iCLK),
        .iRST           (iRST),
        .iStart         (iStart),
        .iControlSignal (iControlSignal),
        .iA             (iA),
        .iB             (iB),
        .oBusy          (oBusy),
        .oDone          (oDone),
        .oHI            (oHI),
        .oLO            (oLO)
    );

    always #5 iCLK = ~iCLK;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [63:0] ref_result(input logic [4:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [63:0] acc);
        longint      sa;
        longint      sb;
        logic [63:0] ps;
        logic [63:0] pu;
        int          qa;
        int          qb;
        sa = $signed(a);
        sb = $signed(b);
        ps = sa * sb;
        pu = {32'd0, a} * {32'd0, b};
        qa = $signed(a);
        qb = $signed(b);
        case (op)
            OPMULT:  return ps;
            OPMULTU: return pu;
            OPMADD:  return acc + ps;
            OPMADDU: return acc + pu;
            OPMSUB:  return acc - ps;
            OPMSUBU: return acc - pu;
            OPDIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(qa % qb), 32'(qa / qb)};
            end
            OPDIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return acc;
        endcase
    endfunction

    function automatic logic is_iter(input logic [4:0] op);
        return op inside {OPMULT, OPMULTU, OPDIV, OPDIVU, OPMADD, OPMADDU, OPMSUB, OPMSUBU};
    endfunction

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_wait = 0;
    logic [63:0] m_pend = 64'd0;
    bit          cmp_en = 1'b0;

    // An accepted iterative op lands its result 33 edges after acceptance
    always @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0; m_done = 1'b0; m_wait = 0;
        end else begin
            m_done = 1'b0;
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (iStart) begin
                if (is_iter(iControlSignal)) begin
                    m_pend = ref_result(iControlSignal, iA, iB, {m_hi, m_lo});
                    m_wait = 33;
                    m_busy = 1'b1;
                end else if (iControlSignal == OPMTHI) begin
                    m_hi = iA;
                    m_done = 1'b1;
                end else if (iControlSignal == OPMTLO) begin
                    m_lo = iA;
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge iCLK) begin
        if (cmp_en) begin
            checks++;
            if (oBusy !== m_busy || oDone !== m_done || oHI !== m_hi || oLO !== m_lo) begin
                errors++;
                $display("FAIL cycle_compare @%0t: busy/done/hi/lo got %b/%b/%h/%h expected %b/%b/%h/%h",
                         $time, oBusy, oDone, oHI, oLO, m_busy, m_done, m_hi, m_lo);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issue one request; done_t is the negedge index after the accept edge
    // where oDone was seen (0 if never within bound).
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, input int bound,
                          output int done_t, output int busy_n);
        @(posedge iCLK); #1;
        iStart = 1'b1; iControlSignal = op; iA = a; iB = b;
        @(posedge iCLK); #1;
        iStart = 1'b0; iControlSignal = 5'($urandom); iA = $urandom; iB = $urandom;
        done_t = 0;
        busy_n = 0;
        for (int t = 1; t <= bound; t++) begin
            @(negedge iCLK);
            if (oBusy) busy_n++;
            if (t == inject_at) begin
                iStart = 1'b1; iControlSignal = OPMULT; iA = 32'd9; iB = 32'd9;
            end
            if (t == inject_at + 1) iStart = 1'b0;
            if (oDone) begin
                done_t = t;
                break;
            end
        end
        iStart = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    logic [4:0] codes [12] = '{OPMULT, OPMULTU, OPDIV, OPDIVU, OPMADD, OPMADDU,
                               OPMSUB, OPMSUBU, OPMTHI, OPMTLO, OPADD, OPSUB};

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int t;
        int bn;
        int exp_t;
        int dones;
        logic [4:0] op;

        #1 iRST = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(posedge iCLK);
        #1 iRST = 1'b1;
        @(negedge iCLK);
        check("reset HI", oHI, 0);
        check("reset LO", oLO, 0);
        check("reset busy", oBusy, 0);
        check("reset done", oDone, 0);

        run_op(OPMULT, 32'hFFFF_FFFD, 32'd7, 0, 40, t, bn);
        check("MULT -3*7 HI", oHI, 32'hFFFF_FFFF);
        check("MULT -3*7 LO", oLO, 32'hFFFF_FFEB);
        check("MULT done latency", t, 34);
        check("MULT busy cycles", bn, 33);

        run_op(OPDIVU, 32'd100, 32'd7, 0, 40, t, bn);
        check("DIVU 100/7 LO", oLO, 32'd14);
        check("DIVU 100/7 HI", oHI, 32'd2);

        run_op(OPDIV, 32'hFFFF_FFF9, 32'd2, 0, 40, t, bn);
        check("DIV -7/2 LO", oLO, 32'hFFFF_FFFD);
        check("DIV -7/2 HI", oHI, 32'hFFFF_FFFF);

        run_op(OPDIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 40, t, bn);
        check("DIV ovf LO", oLO, 32'h8000_0000);
        check("DIV ovf HI", oHI, 32'd0);

        run_op(OPMTHI, 32'd5, 32'd0, 0, 40, t, bn);
        check("MTHI latency", t, 1);
        check("MTHI busy", bn, 0);
        check("MTHI HI", oHI, 32'd5);
        run_op(OPMTLO, 32'd10, 32'd0, 0, 40, t, bn);
        check("MTLO LO", oLO, 32'd10);

        // 0x5_0000000A + 0x1_FFFFFFFE = 0x7_00000008
        run_op(OPMADDU, 32'hFFFF_FFFF, 32'd2, 0, 40, t, bn);
        check("MADDU HI", oHI, 32'd7);
        check("MADDU LO", oLO, 32'd8);
        run_op(OPMSUB, 32'd1, 32'd1, 0, 40, t, bn);
        check("MSUB HI", oHI, 32'd7);
        check("MSUB LO", oLO, 32'd7);

        // Divide by zero with a MULT request injected mid-run
        run_op(OPDIV, 32'd1234, 32'd0, 5, 40, t, bn);
        check("DIV0 LO", oLO, 32'hFFFF_FFFF);
        check("DIV0 HI", oHI, 32'd1234);
        check("DIV0 latency", t, 34);
        repeat (3) @(negedge iCLK);
        check("injected start ignored HI", oHI, 32'd1234);
        check("injected start ignored busy", oBusy, 0);

        // Reset in the middle of a MULTU
        @(posedge iCLK); #1;
        iStart = 1'b1; iControlSignal = OPMULTU; iA = 32'h1234_5678; iB = 32'h9ABC_DEF0;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        repeat (10) @(negedge iCLK);
        #2 iRST = 1'b0;
        @(posedge iCLK); #1 iRST = 1'b1;
        @(negedge iCLK);
        check("mid-reset HI", oHI, 0);
        check("mid-reset LO", oLO, 0);
        check("mid-reset busy", oBusy, 0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge iCLK);
            if (oDone) dones++;
        end
        check("mid-reset no done", dones, 0);

        run_op(OPMULTU, 32'd3, 32'd4, 0, 40, t, bn);
        check("MULTU 3*4 LO", oLO, 32'd12);
        check("MULTU 3*4 HI", oHI, 32'd0);

        run_op(OPADD, 32'd77, 32'd88, 0, 4, t, bn);
        check("OPADD no done", t, 0);
        check("OPADD no busy", bn, 0);
        check("OPADD HI kept", oHI, 32'd0);
        check("OPADD LO kept", oLO, 32'd12);

        // Randomised traffic, back-to-back where possible
        for (int n = 0; n < 60; n++) begin
            op = codes[$urandom_range(0, 11)];
            exp_t = is_iter(op) ? 34 : ((op == OPMTHI || op == OPMTLO) ? 1 : 0);
            run_op(op, pick_operand(), pick_operand(), 0, (exp_t == 0) ? 4 : 40, t, bn);
            check("random op latency", t, exp_t);
        end

        repeat (2) @(negedge iCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
